// File: rtl/mux_sequencer_if.sv
// mux_sequencer_if: control inputs and row-multiplexing outputs of the mux sequencer.
interface mux_sequencer_if #(
    parameter int NB_MUX = 8,
    parameter int RW     = $clog2(NB_MUX)
);
    logic              enable;
    logic              position_sync;
    logic              row_advance;
    logic [NB_MUX-1:0] mux_out;
    logic [RW-1:0]     row_index;
    logic              frame_start;
    logic              busy;
    logic              overrun;
    modport master (
        output enable, position_sync, row_advance,
        input  mux_out, row_index, frame_start, busy, overrun
    );
    modport slave (
        input  enable, position_sync, row_advance,
        output mux_out, row_index, frame_start, busy, overrun
    );
endinterface

// File: rtl/mux_sequencer.sv
// mux_sequencer: steps the one-hot LED row select on each driver latch, with
// guaranteed all-off dead time between rows and revolution sync.
module mux_sequencer #(
    parameter int NB_MUX    = 8,
    parameter int DEAD_TIME = 4,
    parameter int RW        = $clog2(NB_MUX)
) (
    input logic clk,
    input logic rst,
    mux_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEAD_TIME + 1);
    localparam logic [NB_MUX-1:0] ONE = NB_MUX'(1);
    typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [NB_MUX-1:0] mux_q, mux_d;
    logic              fs_q, fs_d;
    logic              busy_q, busy_d;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (!bus.enable) begin
            state_d   = IDLE;
            row_d     = '0;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = DEAD;
            row_d   = '0;
            cnt_d   = CW'(DEAD_TIME);
        end else if (bus.position_sync) begin
            state_d   = DEAD;
            row_d     = '0;
            cnt_d     = CW'(DEAD_TIME);
            pending_d = 1'b0;
        end else if (state_q == DEAD) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q <= CW'(1)) ? ON : DEAD;
            if (bus.row_advance) begin
                pending_d = 1'b1;
                overrun_d = overrun_q | pending_q;
            end
        end else if (bus.row_advance || pending_q) begin
            // a queued advance is honoured after the row has been lit for one cycle
            state_d   = DEAD;
            row_d     = (row_q == RW'(NB_MUX - 1)) ? '0 : row_q + RW'(1);
            cnt_d     = CW'(DEAD_TIME);
            pending_d = 1'b0;
            overrun_d = overrun_q | (bus.row_advance & pending_q);
        end
        mux_d  = (state_d == ON) ? ONE << row_d : '0;
        fs_d   = (state_d == ON) && (state_q != ON) && (row_d == '0);
        busy_d = (state_d == DEAD);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            mux_q     <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mux_q     <= mux_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.mux_out     = mux_q;
    assign bus.row_index   = row_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
endmodule
